i2c_reg_access: RTL and testbench

I2C_REG_ACCESS -- requirements
Module: i2c_reg_access

---
 rtl/i2c_reg_access.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_reg_access.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_access.sv
// i2c_reg_access: turns one host register read/write request into the byte
// sequence for a downstream i2c_master and returns a single response.
// Build option: define I2C_REG_ADDR16_EN for 16-bit register addresses sent as
// two bytes (high byte first). The default build uses 8-bit register addresses.
module i2c_reg_access (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic [6:0]  dev_addr,
`ifdef I2C_REG_ADDR16_EN
    input  logic [15:0] reg_addr,
`else
    input  logic [7:0]  reg_addr,
`endif
    input  logic [7:0]  wr_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [1:0]  rsp_err,
    output logic        transfer_start,
    output logic        transfer_continues,
    output logic        mode,
    output logic [7:0]  data_tx,
    input  logic        transfer_ready,
    input  logic        interrupt,
    input  logic        transaction_complete,
    input  logic        nack,
    input  logic [7:0]  data_rx,
    input  logic        start_err,
    input  logic        arbitration_err
);

`ifdef I2C_REG_ADDR16_EN
    localparam int unsigned RegBytes = 2;
`else
    localparam int unsigned RegBytes = 1;
`endif
    localparam int unsigned RegW = 8 * RegBytes;

    // Byte indices: 0 = device address, RegBytes = low register byte,
    // then wr_data (write) or {dev,1} and the received byte (read).
    localparam logic [2:0] IdxRegLo = 3'(RegBytes);
    localparam logic [2:0] IdxDevRd = IdxRegLo + 3'd1;
    localparam logic [2:0] LastWr   = IdxRegLo + 3'd1;
    localparam logic [2:0] LastRd   = IdxRegLo + 3'd2;

    typedef enum logic [1:0] {StIdle, StXfer, StWaitFree, StResp} state_e;

    typedef struct packed {
        logic       start;
        logic       cont;
        logic       rx;
        logic [7:0] data;
    } byte_t;

    // Parked master inputs: reading 8'hFF without continuing ends in STOP.
    localparam byte_t IdleByte = '{start: 1'b0, cont: 1'b0, rx: 1'b1, data: 8'hFF};

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic            nack_q, nack_d;
    logic            lost_q, lost_d;
    logic            live_q, live_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            rd_q;
    logic [6:0]      dev_q;
    logic [RegW-1:0] reg_q;
    logic [7:0]      wd_q;
    logic            accept;
    logic [2:0]      last_idx;
    logic            is_rx;
    byte_t           out;

    // The master handles interrupts itself; completion is all this block needs.
    logic unused_interrupt;
    assign unused_interrupt = interrupt;

    // Descriptor (start/continues/mode/data) of byte i of the latched request.
    function automatic byte_t byte_at(input logic [2:0] i, input logic rd,
                                      input logic [6:0] dev, input logic [RegW-1:0] ra,
                                      input logic [7:0] wd);
        byte_t b;
        b = IdleByte;
        if (i == 3'd0) begin
            b = '{1'b1, 1'b1, 1'b0, {dev, 1'b0}};
`ifdef I2C_REG_ADDR16_EN
        end else if (i == 3'd1) begin
            b = '{1'b0, 1'b1, 1'b0, ra[15:8]};
`endif
        end else if (i == IdxRegLo) begin
            // A read stops continuing here so the master issues a repeated start.
            b = '{1'b0, ~rd, 1'b0, ra[7:0]};
        end else if (!rd) begin
            b = '{1'b0, 1'b0, 1'b0, wd};
        end else if (i == IdxDevRd) begin
            b = '{1'b1, 1'b1, 1'b0, {dev, 1'b1}};
        end else begin
            b = '{1'b0, 1'b0, 1'b1, 8'hFF};
        end
        return b;
    endfunction

    assign last_idx = rd_q ? LastRd : LastWr;
    assign is_rx    = rd_q && (idx_q == LastRd);
    assign accept   = (state_q == StIdle) && req_valid;

    // Next state, look-ahead master outputs and handshake outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        nack_d     = nack_q;
        lost_d     = lost_q;
        live_d     = live_q;
        rsp_data_d = rsp_data_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        out        = IdleByte;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    idx_d      = 3'd0;
                    nack_d     = 1'b0;
                    lost_d     = 1'b0;
                    live_d     = 1'b1;
                    rsp_data_d = 8'h00;
                    state_d    = StXfer;
                end
            end
            StXfer: begin
                if (start_err || arbitration_err) begin
                    // Bus lost wins over a simultaneous completion.
                    lost_d  = 1'b1;
                    state_d = StWaitFree;
                end else if (transaction_complete) begin
                    if (is_rx) begin
                        rsp_data_d = data_rx;
                    end else if (nack) begin
                        nack_d = 1'b1;
                    end
                    if (idx_q == last_idx) begin
                        state_d = StWaitFree;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        out   = byte_at(idx_q + 3'd1, rd_q, dev_q, reg_q, wd_q);
                    end
                end else begin
                    out = byte_at(idx_q, rd_q, dev_q, reg_q, wd_q);
                end
            end
            StWaitFree: begin
                // After a reset there is no live request, so no response is owed.
                if (transfer_ready) begin
                    state_d = live_q ? StResp : StIdle;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    live_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StWaitFree;
        endcase
    end

    assign transfer_start     = out.start;
    assign transfer_continues = out.cont;
    assign mode               = out.rx;
    assign data_tx            = out.data;
    assign rsp_data           = rsp_data_q;
    assign rsp_err            = lost_q ? 2'b10 : (nack_q ? 2'b01 : 2'b00);

    // State and flag registers; reset parks in WAIT_FREE since the master may be busy.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state_q    <= StWaitFree;
            idx_q      <= 3'd0;
            nack_q     <= 1'b0;
            lost_q     <= 1'b0;
            live_q     <= 1'b0;
            rsp_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            nack_q     <= nack_d;
            lost_q     <= lost_d;
            live_q     <= live_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Request field capture on acceptance.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            rd_q  <= 1'b0;
            dev_q <= 7'h00;
            reg_q <= '0;
            wd_q  <= 8'h00;
        end else if (accept) begin
            rd_q  <= req_read;
            dev_q <= dev_addr;
            reg_q <= reg_addr;
            wd_q  <= wr_data;
        end
    end

endmodule

// File: tb/tb_i2c_reg_access.sv
// tb_i2c_reg_access: directed bench with a small i2c_master/slave model that
// logs the bus as START/Sr-flagged bytes, received bytes and STOP.
`timescale 1ns/1ps
module tb_i2c_reg_access;

`ifdef I2C_REG_ADDR16_EN
    localparam int RW = 16;
`else
    localparam int RW = 8;
`endif
    localparam int StartF = 'h200;
    localparam int RxF    = 'h100;
    localparam int StopC  = 'h400;
    localparam int IdleOut = 'h1FF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          req_valid, req_ready, req_read;
    logic [6:0]    dev_addr;
    logic [RW-1:0] reg_addr;
    logic [7:0]    wr_data;
    logic          rsp_valid, rsp_ready;
    logic [7:0]    rsp_data;
    logic [1:0]    rsp_err;
    logic          transfer_start, transfer_continues, mode;
    logic [7:0]    data_tx;
    logic          transfer_ready, interrupt, transaction_complete, nack;
    logic [7:0]    data_rx;
    logic          start_err, arbitration_err;

    i2c_reg_access dut (
        .clk_in(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .transfer_start(transfer_start), .transfer_continues(transfer_continues),
        .mode(mode), .data_tx(data_tx),
        .transfer_ready(transfer_ready), .interrupt(interrupt),
        .transaction_complete(transaction_complete), .nack(nack), .data_rx(data_rx),
        .start_err(start_err), .arbitration_err(arbitration_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- master + slave model (acts on negedge, samples 2ns later)
    int         log_q[$];
    int         exp_q[$];
    logic [7:0] slave_rd = 8'h3C;
    logic       nack_t   = 1'b0;
    int         m_state  = 0;  // 0 idle, 1 byte, 2 stop/release
    int         m_cnt    = 0;
    logic       m_cont   = 1'b0;
    logic       m_mode   = 1'b0;

    task automatic latch_byte(input logic st);
        int code;
        m_cont = transfer_continues;
        m_mode = mode;
        code = st ? StartF : 0;
        code = code | (mode ? (RxF | int'(slave_rd)) : int'(data_tx));
        log_q.push_back(code);
        m_state = 1;
        m_cnt = 3;
    endtask

    initial begin
        transfer_ready = 1'b1;
        transaction_complete = 1'b0;
        interrupt = 1'b0;
        nack = 1'b0;
        data_rx = 8'h00;
        forever begin
            @(negedge clk);
            transaction_complete = 1'b0;
            interrupt = 1'b0;
            nack = 1'b0;
            data_rx = 8'h00;
            transfer_ready = (m_state == 0);
            if (m_state == 1 && m_cnt == 0) begin
                transaction_complete = 1'b1;
                interrupt = 1'b1;
                if (m_mode) begin
                    data_rx = slave_rd;
                    nack = 1'b1;  // master NACKs the final read byte
                end else begin
                    nack = nack_t;
                end
            end
            #2;
            if ((start_err || arbitration_err) && m_state == 1) begin
                m_state = 2;
                m_cnt = 2;
            end else begin
                case (m_state)
                    0: if (transfer_start) latch_byte(1'b1);
                    1: begin
                        if (m_cnt > 0) m_cnt--;
                        else if (m_cont) latch_byte(1'b0);
                        else if (transfer_start) latch_byte(1'b1);
                        else begin
                            log_q.push_back(StopC);
                            m_state = 2;
                            m_cnt = 2;
                        end
                    end
                    default: begin
                        if (m_cnt > 0) m_cnt--;
                        else m_state = 0;
                    end
                endcase
            end
        end
    end

    // ---------------- helpers
    function automatic int outs();
        return int'({transfer_start, transfer_continues, mode, data_tx});
    endfunction

    task automatic push_reg(input logic [RW-1:0] ra);
`ifdef I2C_REG_ADDR16_EN
        exp_q.push_back(int'(ra[15:8]));
`endif
        exp_q.push_back(int'(ra[7:0]));
    endtask

    task automatic exp_write(input logic [6:0] dev, input logic [RW-1:0] ra, input logic [7:0] wd);
        exp_q.delete();
        exp_q.push_back(StartF | int'({dev, 1'b0}));
        push_reg(ra);
        exp_q.push_back(int'(wd));
        exp_q.push_back(StopC);
    endtask

    task automatic exp_read(input logic [6:0] dev, input logic [RW-1:0] ra, input logic [7:0] rd);
        exp_q.delete();
        exp_q.push_back(StartF | int'({dev, 1'b0}));
        push_reg(ra);
        exp_q.push_back(StartF | int'({dev, 1'b1}));
        exp_q.push_back(RxF | int'(rd));
        exp_q.push_back(StopC);
    endtask

    task automatic check_log(input string tag);
        check($sformatf("%s_len", tag), log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), log_q[i], exp_q[i]);
    endtask

    task automatic issue(input logic rd, input logic [6:0] dev, input logic [RW-1:0] ra,
                         input logic [7:0] wd);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_read = rd; dev_addr = dev; reg_addr = ra; wr_data = wd;
        n = 0;
        #1;
        while (!req_ready && n < 200) begin @(negedge clk); #1; n++; end
        check("req_ready_wait", {31'd0, n < 200}, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [7:0] ed, input logic [1:0] ee);
        int n;
        logic [1:0] e0;
        n = 0;
        #1;
        while (!rsp_valid && n < 500) begin @(negedge clk); #1; n++; end
        check({tag, "_rsp_wait"}, {31'd0, n < 500}, 1);
        e0 = rsp_err;
        check({tag, "_rsp_data"}, rsp_data, ed);
        check({tag, "_rsp_err"}, rsp_err, ee);
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_rsp_hold"}, {rsp_valid, rsp_err}, {1'b1, e0});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check({tag, "_back_idle"}, {rsp_valid, req_ready}, 2'b01);
        check({tag, "_idle_outs"}, outs(), IdleOut);
    endtask

    // ---------------- stimulus
    int n;
    logic seen_rsp;

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_read = 1'b0; dev_addr = '0; reg_addr = '0;
        wr_data = '0; rsp_ready = 1'b0; start_err = 1'b0; arbitration_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_handshake", {req_ready, rsp_valid}, 2'b00);
        check("rst_rsp", {rsp_data, rsp_err}, 10'h000);
        check("rst_outs", outs(), IdleOut);
        @(negedge clk);
        reset_n = 1'b1;

        // write, slave ACKs
        log_q.delete();
        issue(1'b0, 7'h50, RW'('h10), 8'hA5);
        wait_rsp("wr", 8'h00, 2'b00);
        exp_write(7'h50, RW'('h10), 8'hA5);
        check_log("wr");

        // read, slave returns 3C
        log_q.delete();
        slave_rd = 8'h3C;
        issue(1'b1, 7'h50, RW'('h10), 8'h00);
        wait_rsp("rd", 8'h3C, 2'b00);
        exp_read(7'h50, RW'('h10), 8'h3C);
        check_log("rd");

        // second read with a different address/data pattern
        log_q.delete();
        slave_rd = 8'h5E;
        issue(1'b1, 7'h50, RW'('h1234), 8'h00);
        wait_rsp("rd2", 8'h5E, 2'b00);
        exp_read(7'h50, RW'('h1234), 8'h5E);
        check_log("rd2");

        // absent device: every byte NACKed, full sequence still runs
        log_q.delete();
        nack_t = 1'b1;
        issue(1'b0, 7'h22, RW'('h10), 8'h5A);
        wait_rsp("nak", 8'h00, 2'b01);
        exp_write(7'h22, RW'('h10), 8'h5A);
        check_log("nak");
        nack_t = 1'b0;

        // arbitration lost on the completion cycle of byte 1
        log_q.delete();
        fork
            begin
                issue(1'b0, 7'h50, RW'('h10), 8'hA5);
                wait_rsp("arb", 8'h00, 2'b10);
            end
            begin
                n = 0;
                while (log_q.size() < 2 && n < 200) begin @(negedge clk); n++; end
                check("arb_byte1_wait", {31'd0, n < 200}, 1);
                repeat (3) @(negedge clk);
                arbitration_err = 1'b1;
                #1;
                check("arb_outs_same_cycle", outs(), IdleOut);
                @(negedge clk);
                arbitration_err = 1'b0;
            end
        join
        exp_write(7'h50, RW'('h10), 8'hA5);
        exp_q = exp_q[0:1];
        check_log("arb");

        // one-cycle reset mid-read with the next request held
        log_q.delete();
        slave_rd = 8'h3C;
        issue(1'b1, 7'h50, RW'('h10), 8'h00);
        n = 0;
        while (log_q.size() < 3 && n < 200) begin @(negedge clk); n++; end
        check("rst_mid_wait", {31'd0, n < 200}, 1);
        @(negedge clk);
        reset_n = 1'b0;
        req_valid = 1'b1; req_read = 1'b0; dev_addr = 7'h50; reg_addr = RW'('h20);
        wr_data = 8'hC3;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_mid_state", {req_ready, rsp_valid}, 2'b00);
        check("rst_mid_outs", outs(), IdleOut);
        seen_rsp = 1'b0;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk); #1; n++;
            if (rsp_valid) seen_rsp = 1'b1;
        end
        check("rst_mid_ready_wait", {31'd0, n < 200}, 1);
        check("rst_mid_no_rsp", seen_rsp, 1'b0);
        check("rst_mid_master_idle", m_state, 0);
        exp_read(7'h50, RW'('h10), 8'h3C);
        check_log("rst_abort");
        log_q.delete();
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp("post_rst", 8'h00, 2'b00);
        exp_write(7'h50, RW'('h20), 8'hC3);
        check_log("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
